// File: rtl/alu_pkg.sv
// Shared ALU types: opcode enumeration and the {n, v, c, z} flag record.
package alu_pkg;

  // Width of the encoded opcode field; wider op ports must keep upper bits zero.
  localparam int unsigned AluOpWidth = 4;

  typedef enum logic [AluOpWidth-1:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAdc   = 4'd2,
    OpSbb   = 4'd3,
    OpAnd   = 4'd4,
    OpOr    = 4'd5,
    OpXor   = 4'd6,
    OpPassB = 4'd7,
    OpCmp   = 4'd8,
    OpShl   = 4'd9,
    OpShr   = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, flags and illegal-opcode indication.
// Shift ops exist only when ALU_PIPE_SHIFT_EN is defined; otherwise they decode as illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OP_BITS   = 4
) (
  input  logic [OP_BITS-1:0]   op_i,
  input  logic [DATA_BITS-1:0] a_i,
  input  logic [DATA_BITS-1:0] b_i,
  input  logic                 carry_i,
  output logic [DATA_BITS-1:0] result_o,
  output logic [3:0]           flags_o,
  output logic                 illegal_o
);

  alu_op_t                op_dec;
  logic                   op_hi_zero;
  logic [DATA_BITS-1:0]   b_op;
  logic                   cin;
  logic [DATA_BITS:0]     sum;
  logic                   ovf;
  logic [DATA_BITS-1:0]   val;
  logic                   cout;
  logic                   vout;
  logic                   bad;
  alu_flags_t             flags;

  assign op_dec     = alu_op_t'(op_i[AluOpWidth-1:0]);
  assign op_hi_zero = ((op_i >> AluOpWidth) == '0);

  // Adder operand selection: subtraction-style ops invert b, carry-in per op.
  always_comb begin
    b_op = b_i;
    cin  = 1'b0;
    case (op_dec)
      OpSub, OpCmp: begin b_op = ~b_i; cin = 1'b1;    end
      OpAdc:        begin              cin = carry_i; end
      OpSbb:        begin b_op = ~b_i; cin = carry_i; end
      default:      ;
    endcase
  end

  // One shared DATA_BITS+1 adder; top bit is the carry (1 = no borrow for subtracts).
  assign sum = {1'b0, a_i} + {1'b0, b_op} + {{DATA_BITS{1'b0}}, cin};
  assign ovf = (a_i[DATA_BITS-1] == b_op[DATA_BITS-1]) &&
               (sum[DATA_BITS-1] != a_i[DATA_BITS-1]);

  // Result select and flag formation; CMP reports a but keeps subtraction flags.
  always_comb begin
    val  = a_i;
    cout = 1'b0;
    vout = 1'b0;
    bad  = 1'b0;
    case (op_dec)
      OpAdd, OpSub, OpAdc, OpSbb, OpCmp: begin
        val  = sum[DATA_BITS-1:0];
        cout = sum[DATA_BITS];
        vout = ovf;
      end
      OpAnd:   val = a_i & b_i;
      OpOr:    val = a_i | b_i;
      OpXor:   val = a_i ^ b_i;
      OpPassB: val = b_i;
`ifdef ALU_PIPE_SHIFT_EN
      OpShl: begin
        val  = {a_i[DATA_BITS-2:0], 1'b0};
        cout = a_i[DATA_BITS-1];
      end
      OpShr: begin
        val  = {1'b0, a_i[DATA_BITS-1:1]};
        cout = a_i[0];
      end
`endif
      default: bad = 1'b1;
    endcase
    if (!op_hi_zero) bad = 1'b1;

    illegal_o = bad;
    if (bad) begin
      result_o = a_i;
      flags    = '0;
    end else begin
      result_o = (op_dec == OpCmp) ? a_i : val;
      flags.n  = val[DATA_BITS-1];
      flags.v  = vout;
      flags.c  = cout;
      flags.z  = (val == '0);
    end
    flags_o = flags;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds the request, S2 holds result/flags.
// Carry register C chains ADC/SBB across back-to-back ops.
// Optional shift ops: define ALU_PIPE_SHIFT_EN (handled in alu_core).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OP_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_BITS-1:0]   op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] result,
  output logic [3:0]           flags,
  output logic                 illegal
);

  logic                 s1_valid_q, s1_valid_d;
  logic [OP_BITS-1:0]   s1_op_q, s1_op_d;
  logic [DATA_BITS-1:0] s1_a_q, s1_a_d;
  logic [DATA_BITS-1:0] s1_b_q, s1_b_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] result_q, result_d;
  alu_flags_t           flags_q, flags_d;
  logic                 illegal_q, illegal_d;
  logic                 carry_q, carry_d;

  logic                 s2_adv;
  logic                 s1_fire;
  logic                 s12_fire;
  logic [DATA_BITS-1:0] core_result;
  logic [3:0]           core_flags;
  alu_flags_t           core_f;
  logic                 core_illegal;

  alu_core #(
    .DATA_BITS (DATA_BITS),
    .OP_BITS   (OP_BITS)
  ) u_core (
    .op_i      (s1_op_q),
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .carry_i   (carry_q),
    .result_o  (core_result),
    .flags_o   (core_flags),
    .illegal_o (core_illegal)
  );

  assign core_f = alu_flags_t'(core_flags);

  // Handshake: S2 drains when empty or consumed; S1 accepts when empty or draining.
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_fire  = in_valid && in_ready;
  assign s12_fire = s1_valid_q && s2_adv;

  // Next-state for both stages and the carry register.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    carry_d     = carry_q;

    if (s1_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) out_valid_d = s1_valid_q;

    if (s12_fire) begin
      result_d  = core_result;
      flags_d   = core_f;
      illegal_d = core_illegal;
      // Illegal ops leave the chained carry untouched.
      if (!core_illegal) carry_d = core_f.c;
    end
  end

  // State registers; asynchronous active-low reset discards in-flight ops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

endmodule
